rename_reg_file: RTL and testbench
==================================

Name: rename_reg_file

Overview:
- Architectural register file with rename tags for the out-of-order core; parametrised successor of the single-commit, two-read register file.
- Holds committed values plus a per-register busy bit and ROB tag.
- Serves N decoder read ports with same-cycle commit bypass, accepts up to C in-order commits per cycle, and discards all rename state on flush (clr_in).
- Sits between decoder/issue and ROB commit.

Parameters:
- XLEN, 32, data width.
- REG_NUM, 32, architectural register count; index width RW = clog2(REG_NUM).
- ROB_IDX_W, 4, ROB tag width.
- NUM_RD, 2, decoder read ports.
- NUM_CMT, 2, commit ports; port 0 is oldest.

Ports:
- clk_in  in  1  clock
- rst_in  in  1  synchronous active-high reset
- rdy_in  in  1  1 = advance; 0 = hold all state
- clr_in  in  1  misprediction flush
- issue_valid  in  1  rename rd this cycle
- issue_rd  in  RW  destination register
- issue_rob_index  in  ROB_IDX_W  tag allocated to the issuing instruction
- rd_addr  in  NUM_RD*RW  packed read indices
- rd_val  out  NUM_RD*XLEN  operand value
- rd_busy  out  NUM_RD  1 = operand pending
- rd_tag  out  NUM_RD*ROB_IDX_W  producer tag; valid only when busy
- cmt_valid  in  NUM_CMT  per-port commit
- cmt_rd  in  NUM_CMT*RW  destination register
- cmt_rob_index  in  NUM_CMT*ROB_IDX_W  committing tag
- cmt_val  in  NUM_CMT*XLEN  result

Behaviour:
- State per register r: val[r] (XLEN), busy[r], tag[r]. Register 0 is hardwired: val 0, never busy, and writes and renames to it are ignored.
- Reset (rst_in=1 at posedge, overrides everything): all val, busy and tag cleared to 0. The read outputs are combinational, so they show 0 / not busy / tag 0 for every address.
- Priority: rst_in > !rdy_in (hold; clr_in and commits ignored) > normal update.
- Read path is combinational, zero latency, computed from current state plus the commit bypass; it does not see this cycle's issue.
  - An instruction reading its own rd gets the old mapping.
- Read port k, address a:
  - If a==0: val 0, busy 0.
  - Else if busy[a] and some valid commit port j has cmt_rob_index[j]==tag[a] (tags unique, at most one matches): rd_val = cmt_val[j], busy 0.
  - Else: val[a], busy[a], tag[a].
- Commit update, sequential, ports processed 0..NUM_CMT-1:
  - val[cmt_rd] <= cmt_val. The youngest port wins on a same-register conflict.
  - busy[cmt_rd] cleared only if tag[cmt_rd]==cmt_rob_index (evaluated on pre-cycle tag). A younger rename keeps the register busy.
- Issue update: if issue_valid and issue_rd!=0, then busy <= 1 and tag <= issue_rob_index.
  - Issue overrides a commit-clear on the same register in the same cycle. The value write from the commit still occurs.
- Flush: clr_in=1 with rdy_in=1 clears every busy bit and zeroes every tag.
  - Commits in the same cycle still write val, since they are architecturally retired.
  - Issue in a flush cycle is ignored.
- Tag 0 is a legal ROB index. Pending status comes only from busy, never from tag!=0.
- rd_tag is don't-care when busy=0; drive 0 for determinism.
- No protocol checks on duplicate tags; the ROB guarantees uniqueness and in-order commit.

Decomposition:
- Shared defines/package: XLEN, REG_NUM, ROB_IDX_W defaults, and the `DATA_TYPE, `REG_INDEX_TYPE, `ROB_INDEX_TYPE macros already in use.
- One sub-module rf_read_port, instantiated NUM_RD times via generate. Inputs: address, state slice, commit bus. Outputs: val/busy/tag with bypass.
- Commit/issue/flush update stays in the top block.

Test Plan:
- Reset then read x5, x0 -> val 0, busy 0; cycle with issue_valid, rd=0, tag 3 -> x0 stays not busy.
- Issue rd=5 tag 2; next cycle read x5 -> busy 1, tag 2. Commit tag 2, val 0xDEADBEEF in that same cycle -> rd_val 0xDEADBEEF, busy 0 (bypass); next cycle -> val 0xDEADBEEF, busy 0 from state.
- Issue rd=7 tag 1, then issue rd=7 tag 4. Commit tag 1, val 0x11 -> val[7]=0x11, busy stays 1, tag 4. Commit tag 4, val 0x44 -> busy 0, val 0x44.
- Dual commit: port0 rd=3 tag 0 val 0xA, port1 rd=3 tag 1 val 0xB, tag[3]=1 -> val[3]=0xB, busy 0. Same setup with tag[3]=0 -> val 0xB, busy 0 (port0 match clears).
- Same cycle: commit tag 2 to x9 (tag[9]=2) and issue rd=9 tag 6 -> val[9] updated, busy 1, tag 6.
- x4, x8 busy; assert clr_in with a commit to x4 val 0x99 -> all busy 0, val[4]=0x99. Repeat with rdy_in=0 -> no state change.

Source files
------------

// File: rtl/rename_reg_file_pkg.sv
// Shared widths and type macros for the rename register file and its read ports.
`ifndef RENAME_REG_FILE_PKG_SV
`define RENAME_REG_FILE_PKG_SV

`define DATA_TYPE(w) logic [(w)-1:0]
`define REG_INDEX_TYPE(w) logic [(w)-1:0]
`define ROB_INDEX_TYPE(w) logic [(w)-1:0]

package rename_reg_file_pkg;
    localparam int unsigned XLEN_DEF      = 32;
    localparam int unsigned REG_NUM_DEF   = 32;
    localparam int unsigned ROB_IDX_W_DEF = 4;
endpackage

`endif

// File: rtl/rf_read_port.sv
// One decoder read port: looks up committed state and forwards a same-cycle commit
// whose tag matches the register's pending producer.
module rf_read_port
    import rename_reg_file_pkg::*;
#(
    parameter int unsigned XLEN      = XLEN_DEF,
    parameter int unsigned REG_NUM   = REG_NUM_DEF,
    parameter int unsigned ROB_IDX_W = ROB_IDX_W_DEF,
    parameter int unsigned NUM_CMT   = 2,
    localparam int unsigned RW       = $clog2(REG_NUM)
) (
    input  logic [RW-1:0]                addr,
    input  logic [XLEN-1:0]              reg_val [REG_NUM],
    input  logic [REG_NUM-1:0]           reg_busy,
    input  logic [ROB_IDX_W-1:0]         reg_tag [REG_NUM],
    input  logic [NUM_CMT-1:0]           cmt_valid,
    input  logic [NUM_CMT*ROB_IDX_W-1:0] cmt_rob_index,
    input  logic [NUM_CMT*XLEN-1:0]      cmt_val,
    output logic [XLEN-1:0]              val,
    output logic                         busy,
    output logic [ROB_IDX_W-1:0]         tag
);

    logic            hit;
    logic [XLEN-1:0] hit_val;

    always_comb begin
        hit     = 1'b0;
        hit_val = '0;
        for (int j = 0; j < int'(NUM_CMT); j++) begin
            if (cmt_valid[j] && cmt_rob_index[j*ROB_IDX_W +: ROB_IDX_W] == reg_tag[addr]) begin
                hit     = 1'b1;
                hit_val = cmt_val[j*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        val  = '0;
        busy = 1'b0;
        tag  = '0;
        if (addr != '0) begin
            if (reg_busy[addr] && hit) begin
                val = hit_val;
            end else begin
                val  = reg_val[addr];
                busy = reg_busy[addr];
                tag  = reg_busy[addr] ? reg_tag[addr] : '0;
            end
        end
    end

endmodule

// File: rtl/rename_reg_file.sv
// Architectural register file with per-register busy bit and ROB tag, multi-port read
// with commit bypass, multi-port in-order commit, issue rename and flush.
module rename_reg_file
    import rename_reg_file_pkg::*;
#(
    parameter int unsigned XLEN      = XLEN_DEF,
    parameter int unsigned REG_NUM   = REG_NUM_DEF,
    parameter int unsigned ROB_IDX_W = ROB_IDX_W_DEF,
    parameter int unsigned NUM_RD    = 2,
    parameter int unsigned NUM_CMT   = 2,
    localparam int unsigned RW       = $clog2(REG_NUM)
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         rdy_in,
    input  logic                         clr_in,
    input  logic                         issue_valid,
    input  logic [RW-1:0]                issue_rd,
    input  logic [ROB_IDX_W-1:0]         issue_rob_index,
    input  logic [NUM_RD*RW-1:0]         rd_addr,
    output logic [NUM_RD*XLEN-1:0]       rd_val,
    output logic [NUM_RD-1:0]            rd_busy,
    output logic [NUM_RD*ROB_IDX_W-1:0]  rd_tag,
    input  logic [NUM_CMT-1:0]           cmt_valid,
    input  logic [NUM_CMT*RW-1:0]        cmt_rd,
    input  logic [NUM_CMT*ROB_IDX_W-1:0] cmt_rob_index,
    input  logic [NUM_CMT*XLEN-1:0]      cmt_val
);

    `DATA_TYPE(XLEN)           val_q [REG_NUM];
    `DATA_TYPE(XLEN)           val_d [REG_NUM];
    `ROB_INDEX_TYPE(ROB_IDX_W) tag_q [REG_NUM];
    `ROB_INDEX_TYPE(ROB_IDX_W) tag_d [REG_NUM];
    logic [REG_NUM-1:0]        busy_q;
    logic [REG_NUM-1:0]        busy_d;
    `REG_INDEX_TYPE(RW)        r;

    // Later (younger) ports overwrite earlier ones; busy-clear compares against the
    // pre-cycle tag so a younger rename keeps the register pending.
    always_comb begin
        val_d  = val_q;
        tag_d  = tag_q;
        busy_d = busy_q;
        r      = '0;
        for (int j = 0; j < int'(NUM_CMT); j++) begin
            r = cmt_rd[j*RW +: RW];
            if (cmt_valid[j] && r != '0) begin
                val_d[r] = cmt_val[j*XLEN +: XLEN];
                if (tag_q[r] == cmt_rob_index[j*ROB_IDX_W +: ROB_IDX_W]) begin
                    busy_d[r] = 1'b0;
                end
            end
        end
        if (clr_in) begin
            busy_d = '0;
            for (int i = 0; i < int'(REG_NUM); i++) begin
                tag_d[i] = '0;
            end
        end else if (issue_valid && issue_rd != '0) begin
            busy_d[issue_rd] = 1'b1;
            tag_d[issue_rd]  = issue_rob_index;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy_q <= '0;
            for (int i = 0; i < int'(REG_NUM); i++) begin
                val_q[i] <= '0;
                tag_q[i] <= '0;
            end
        end else if (rdy_in) begin
            busy_q <= busy_d;
            val_q  <= val_d;
            tag_q  <= tag_d;
        end
    end

    for (genvar k = 0; k < int'(NUM_RD); k++) begin : g_rd
        rf_read_port #(
            .XLEN      (XLEN),
            .REG_NUM   (REG_NUM),
            .ROB_IDX_W (ROB_IDX_W),
            .NUM_CMT   (NUM_CMT)
        ) u_port (
            .addr          (rd_addr[k*RW +: RW]),
            .reg_val       (val_q),
            .reg_busy      (busy_q),
            .reg_tag       (tag_q),
            .cmt_valid     (cmt_valid),
            .cmt_rob_index (cmt_rob_index),
            .cmt_val       (cmt_val),
            .val           (rd_val[k*XLEN +: XLEN]),
            .busy          (rd_busy[k]),
            .tag           (rd_tag[k*ROB_IDX_W +: ROB_IDX_W])
        );
    end

endmodule

// File: tb/tb_rename_reg_file.sv
// Scoreboard bench for rename_reg_file: expected read results are queued with each
// stimulus step and compared against the read ports before the next clock edge.
module tb_rename_reg_file;
    localparam int XLEN = 32;
    localparam int RW   = 5;
    localparam int TW   = 4;
    localparam int NRD  = 2;
    localparam int NCM  = 2;

    logic              clk = 1'b0;
    logic              rst, rdy, clr, issue_valid;
    logic [RW-1:0]     issue_rd;
    logic [TW-1:0]     issue_rob_index;
    logic [NRD*RW-1:0] rd_addr;
    logic [NRD*XLEN-1:0] rd_val;
    logic [NRD-1:0]      rd_busy;
    logic [NRD*TW-1:0]   rd_tag;
    logic [NCM-1:0]      cmt_valid;
    logic [NCM*RW-1:0]   cmt_rd;
    logic [NCM*TW-1:0]   cmt_rob_index;
    logic [NCM*XLEN-1:0] cmt_val;

    typedef struct {
        int                   port;
        logic [XLEN+TW:0]     rsp;  // {val, busy, tag}
        string                name;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    rename_reg_file dut (
        .clk_in          (clk),
        .rst_in          (rst),
        .rdy_in          (rdy),
        .clr_in          (clr),
        .issue_valid     (issue_valid),
        .issue_rd        (issue_rd),
        .issue_rob_index (issue_rob_index),
        .rd_addr         (rd_addr),
        .rd_val          (rd_val),
        .rd_busy         (rd_busy),
        .rd_tag          (rd_tag),
        .cmt_valid       (cmt_valid),
        .cmt_rd          (cmt_rd),
        .cmt_rob_index   (cmt_rob_index),
        .cmt_val         (cmt_val)
    );

    function automatic logic [XLEN+TW:0] obs(input int p);
        return {rd_val[p*XLEN +: XLEN], rd_busy[p], rd_tag[p*TW +: TW]};
    endfunction

    function automatic void expect_rd(input int p, input logic [XLEN-1:0] v, input logic b,
                                      input logic [TW-1:0] t, input string name);
        exp_t x;
        x.port = p;
        x.rsp  = {v, b, t};
        x.name = name;
        exp_q.push_back(x);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; rdy = 1'b1; clr = 1'b0;
        issue_valid = 1'b0; issue_rd = '0; issue_rob_index = '0;
        cmt_valid = '0; cmt_rd = '0; cmt_rob_index = '0; cmt_val = '0;
    endtask

    task automatic set_cmt(input int j, input logic [RW-1:0] r, input logic [TW-1:0] t,
                           input logic [XLEN-1:0] v);
        cmt_valid[j]            = 1'b1;
        cmt_rd[j*RW +: RW]      = r;
        cmt_rob_index[j*TW +: TW] = t;
        cmt_val[j*XLEN +: XLEN] = v;
    endtask

    task automatic issue(input logic [RW-1:0] r, input logic [TW-1:0] t);
        issue_valid = 1'b1; issue_rd = r; issue_rob_index = t;
    endtask

    task automatic read(input int p, input logic [RW-1:0] a);
        rd_addr[p*RW +: RW] = a;
    endtask

    task automatic test_reset();
        idle(); rst = 1'b1; rd_addr = '0;
        tick();
        rst = 1'b0;
        read(0, 5); read(1, 0);
        expect_rd(0, 0, 0, 0, "reset_x5");
        expect_rd(1, 0, 0, 0, "reset_x0");
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); total++;
            if (obs(e.port) !== e.rsp) $display("FAIL %s: got val_busy_tag=%h want %h", e.name, obs(e.port), e.rsp);
            else passed++;
        end
        issue(0, 3); set_cmt(0, 0, 3, 32'h55);
        tick(); idle();
        expect_rd(1, 0, 0, 0, "x0_ignores_issue_and_commit");
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); total++;
            if (obs(e.port) !== e.rsp) $display("FAIL %s: got val_busy_tag=%h want %h", e.name, obs(e.port), e.rsp);
            else passed++;
        end
    endtask

    task automatic test_issue_bypass();
        idle(); issue(5, 2); read(0, 5);
        tick(); idle();
        expect_rd(0, 0, 1, 2, "x5_busy_after_issue");
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); total++;
            if (obs(e.port) !== e.rsp) $display("FAIL %s: got val_busy_tag=%h want %h", e.name, obs(e.port), e.rsp);
            else passed++;
        end
        set_cmt(1, 5, 2, 32'hDEADBEEF);
        expect_rd(0, 32'hDEADBEEF, 0, 0, "x5_commit_bypass");
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); total++;
            if (obs(e.port) !== e.rsp) $display("FAIL %s: got val_busy_tag=%h want %h", e.name, obs(e.port), e.rsp);
            else passed++;
        end
        tick(); idle();
        expect_rd(0, 32'hDEADBEEF, 0, 0, "x5_committed_state");
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); total++;
            if (obs(e.port) !== e.rsp) $display("FAIL %s: got val_busy_tag=%h want %h", e.name, obs(e.port), e.rsp);
            else passed++;
        end
    endtask

    task automatic test_younger_rename();
        idle(); issue(7, 1); tick();
        issue(7, 4); tick(); idle();
        read(0, 7);
        set_cmt(0, 7, 1, 32'h11);
        expect_rd(0, 0, 1, 4, "x7_stale_commit_no_bypass");
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); total++;
            if (obs(e.port) !== e.rsp) $display("FAIL %s: got val_busy_tag=%h want %h", e.name, obs(e.port), e.rsp);
            else passed++;
        end
        tick(); idle();
        expect_rd(0, 32'h11, 1, 4, "x7_val_written_still_busy");
        set_cmt(0, 7, 4, 32'h44);
        expect_rd(0, 32'h44, 0, 0, "x7_young_commit_bypass");
        // Both entries describe the same sample: first with commit idle, then active.
        e = exp_q.pop_front(); total++;
        cmt_valid = '0; #1;
        if (obs(e.port) !== e.rsp) $display("FAIL %s: got val_busy_tag=%h want %h", e.name, obs(e.port), e.rsp);
        else passed++;
        set_cmt(0, 7, 4, 32'h44); #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); total++;
            if (obs(e.port) !== e.rsp) $display("FAIL %s: got val_busy_tag=%h want %h", e.name, obs(e.port), e.rsp);
            else passed++;
        end
        tick(); idle();
        expect_rd(0, 32'h44, 0, 0, "x7_final_state");
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); total++;
            if (obs(e.port) !== e.rsp) $display("FAIL %s: got val_busy_tag=%h want %h", e.name, obs(e.port), e.rsp);
            else passed++;
        end
    endtask

    task automatic test_dual_commit();
        logic [TW-1:0] pend [2] = '{4'd1, 4'd0};
        logic [XLEN-1:0] fwd [2] = '{32'hB, 32'hA};
        for (int k = 0; k < 2; k++) begin
            idle(); issue(3, pend[k]); tick(); idle();
            read(1, 3);
            set_cmt(0, 3, 0, 32'hA); set_cmt(1, 3, 1, 32'hB);
            expect_rd(1, fwd[k], 0, 0, $sformatf("dual_bypass_tag%0d", pend[k]));
            #1;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front(); total++;
                if (obs(e.port) !== e.rsp) $display("FAIL %s: got val_busy_tag=%h want %h", e.name, obs(e.port), e.rsp);
                else passed++;
            end
            tick(); idle();
            expect_rd(1, 32'hB, 0, 0, $sformatf("dual_state_tag%0d", pend[k]));
            #1;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front(); total++;
                if (obs(e.port) !== e.rsp) $display("FAIL %s: got val_busy_tag=%h want %h", e.name, obs(e.port), e.rsp);
                else passed++;
            end
        end
    endtask

    task automatic test_back_to_back();
        idle(); issue(9, 2); tick(); idle();
        read(0, 9);
        set_cmt(0, 9, 2, 32'h0009_0009); issue(9, 6);
        expect_rd(0, 32'h0009_0009, 0, 0, "x9_bypass_ignores_issue");
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); total++;
            if (obs(e.port) !== e.rsp) $display("FAIL %s: got val_busy_tag=%h want %h", e.name, obs(e.port), e.rsp);
            else passed++;
        end
        tick(); idle();
        expect_rd(0, 32'h0009_0009, 1, 6, "x9_issue_beats_commit_clear");
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); total++;
            if (obs(e.port) !== e.rsp) $display("FAIL %s: got val_busy_tag=%h want %h", e.name, obs(e.port), e.rsp);
            else passed++;
        end
    endtask

    task automatic test_flush();
        idle(); issue(4, 5); tick();
        issue(8, 7); tick(); idle();
        rdy = 1'b0; clr = 1'b1; set_cmt(0, 4, 9, 32'h77); issue(10, 3);
        tick(); idle();
        read(0, 4); read(1, 8);
        expect_rd(0, 0, 1, 5, "hold_x4_unchanged");
        expect_rd(1, 0, 1, 7, "hold_x8_unchanged");
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); total++;
            if (obs(e.port) !== e.rsp) $display("FAIL %s: got val_busy_tag=%h want %h", e.name, obs(e.port), e.rsp);
            else passed++;
        end
        clr = 1'b1; set_cmt(0, 4, 9, 32'h99); issue(10, 3);
        tick(); idle();
        expect_rd(0, 32'h99, 0, 0, "flush_x4_val_kept");
        expect_rd(1, 0, 0, 0, "flush_x8_cleared");
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); total++;
            if (obs(e.port) !== e.rsp) $display("FAIL %s: got val_busy_tag=%h want %h", e.name, obs(e.port), e.rsp);
            else passed++;
        end
        read(0, 10);
        expect_rd(0, 0, 0, 0, "flush_drops_issue_x10");
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); total++;
            if (obs(e.port) !== e.rsp) $display("FAIL %s: got val_busy_tag=%h want %h", e.name, obs(e.port), e.rsp);
            else passed++;
        end
    endtask

    initial begin
        rd_addr = '0;
        idle();
        test_reset();
        test_issue_bypass();
        test_younger_rename();
        test_dual_commit();
        test_back_to_back();
        test_flush();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
